alu_issue_queue: RTL and testbench



---
 rtl/alu_issue_queue.sv | 183 ++++++++++++++++++
 tb/tb_alu_issue_queue.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// Request FIFO and issue sequencer for the alu block. Operations are spaced by command latency.
// Define ALU_ISSUE_SPLIT_EN to enable the two-cycle split-operand path (INP_VALID 01 then 10).
module alu_issue_queue #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int GAP_STD = 1,
  parameter int GAP_MUL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_mode,
  input  logic [3:0]       req_cmd,
  input  logic [WIDTH-1:0] req_opa,
  input  logic [WIDTH-1:0] req_opb,
  input  logic             req_cin,
  input  logic             req_split,
  input  logic             hold,
  output logic [1:0]       inp_valid,
  output logic             mode,
  output logic [3:0]       cmd,
  output logic [WIDTH-1:0] opa,
  output logic [WIDTH-1:0] opb,
  output logic             cin,
  output logic             ce,
  output logic [15:0]      issue_cnt
);
  localparam int AW   = $clog2(DEPTH);
  localparam int GMAX = (GAP_MUL > GAP_STD) ? GAP_MUL : GAP_STD;
  localparam int GW   = $clog2(GMAX + 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic             mode;
    logic [3:0]       cmd;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             cin;
`ifdef ALU_ISSUE_SPLIT_EN
    logic             split;
`endif
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_AB,
`ifdef ALU_ISSUE_SPLIT_EN
    S_ISSUE_A,
    S_ISSUE_B,
`endif
    S_GAP
  } state_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry, head, cur;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            run, push, pop, cur_mul;
  logic [GW-1:0]   gap_left, gap_init;
  state_t          state, issue_next;

  // run holds req_ready low until the first edge after reset release.
  assign req_ready = run && (count != FULL_CNT);
  assign push      = req_valid && req_ready;
  assign head      = mem[rd_ptr];
  assign pop       = !hold && (count != '0) &&
                     ((state == S_IDLE) || ((state == S_GAP) && (gap_left == '0)));
  assign cur_mul   = cur.mode && ((cur.cmd == 4'd9) || (cur.cmd == 4'd10));
  assign gap_init  = cur_mul ? GW'(GAP_MUL - 1) : GW'(GAP_STD - 1);

`ifdef ALU_ISSUE_SPLIT_EN
  assign issue_next = head.split ? S_ISSUE_A : S_ISSUE_AB;
`else
  assign issue_next = S_ISSUE_AB;
  logic unused_split;
  assign unused_split = req_split;
`endif

  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    wr_entry      = '0;
    wr_entry.mode = req_mode;
    wr_entry.cmd  = req_cmd;
    wr_entry.opa  = req_opa;
    wr_entry.opb  = req_opb;
    wr_entry.cin  = req_cin;
`ifdef ALU_ISSUE_SPLIT_EN
    wr_entry.split = req_split;
`endif
  end

  // NOTE: the storage array is not reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      run    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      run <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Outputs are loaded on the edge that leaves each issue state, so the ALU sees them one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cur       <= '0;
      gap_left  <= '0;
      inp_valid <= 2'b00;
      mode      <= 1'b0;
      cmd       <= '0;
      opa       <= '0;
      opb       <= '0;
      cin       <= 1'b0;
      ce        <= 1'b0;
      issue_cnt <= '0;
    end else begin
      ce <= !hold;
      if (!hold) begin
        case (state)
          S_IDLE: begin
            inp_valid <= 2'b00;
            if (pop) begin
              cur   <= head;
              state <= issue_next;
            end
          end
          S_ISSUE_AB: begin
            inp_valid <= 2'b11;
            mode      <= cur.mode;
            cmd       <= cur.cmd;
            opa       <= cur.opa;
            opb       <= cur.opb;
            cin       <= cur.cin;
            gap_left  <= gap_init;
            issue_cnt <= issue_cnt + 16'd1;
            state     <= S_GAP;
          end
`ifdef ALU_ISSUE_SPLIT_EN
          S_ISSUE_A: begin
            inp_valid <= 2'b01;
            mode      <= cur.mode;
            cmd       <= cur.cmd;
            opa       <= cur.opa;
            opb       <= '0;
            cin       <= cur.cin;
            state     <= S_ISSUE_B;
          end
          S_ISSUE_B: begin
            inp_valid <= 2'b10;
            opb       <= cur.opb;
            gap_left  <= gap_init;
            issue_cnt <= issue_cnt + 16'd1;
            state     <= S_GAP;
          end
`endif
          S_GAP: begin
            inp_valid <= 2'b00;
            if (gap_left != '0) begin
              gap_left <= gap_left - GW'(1);
            end else if (pop) begin
              cur   <= head;
              state <= issue_next;
            end else begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue; directed scenarios plus a randomized scoreboard run.
// Split-path scenarios are compiled in when ALU_ISSUE_SPLIT_EN is defined.
module tb_alu_issue_queue;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int GAP_STD = 1;
  localparam int GAP_MUL = 2;
`ifdef ALU_ISSUE_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req_valid, req_ready, req_mode, req_cin, req_split, hold;
  logic [3:0] req_cmd, cmd;
  logic [WIDTH-1:0] req_opa, req_opb, opa, opb;
  logic [1:0] inp_valid;
  logic mode, cin, ce;
  logic [15:0] issue_cnt;

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_cnt = '0;

  typedef struct { logic m; logic [3:0] c; logic [7:0] a; logic [7:0] b; logic ci; logic sp; } req_t;
  typedef struct { logic [1:0] v; logic m; logic [3:0] c; logic [7:0] a; logic [7:0] b;
                   logic ci; logic ce; logic [15:0] n; } obs_t;

  alu_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP_STD(GAP_STD), .GAP_MUL(GAP_MUL)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_cmd(req_cmd), .req_opa(req_opa), .req_opb(req_opb),
    .req_cin(req_cin), .req_split(req_split), .hold(hold), .inp_valid(inp_valid),
    .mode(mode), .cmd(cmd), .opa(opa), .opb(opb), .cin(cin), .ce(ce), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input req_t r, input logic v);
    req_valid = v; req_mode = r.m; req_cmd = r.c; req_opa = r.a;
    req_opb = r.b; req_cin = r.ci; req_split = r.sp;
  endtask

  function automatic obs_t sample();
    obs_t s;
    s = '{inp_valid, mode, cmd, opa, opb, cin, ce, issue_cnt};
    return s;
  endfunction

  function automatic int gap_of(input req_t r);
    return (r.m && (r.c == 4'd9 || r.c == 4'd10)) ? GAP_MUL : GAP_STD;
  endfunction

  function automatic logic [1:0] first_kind(input req_t r);
    return (SPLIT_EN && r.sp) ? 2'b01 : 2'b11;
  endfunction

  function automatic req_t rand_std();
    req_t r;
    r = '{1'($urandom_range(0, 1)), 4'($urandom_range(0, 8)), 8'($urandom), 8'($urandom),
          1'($urandom_range(0, 1)), 1'b0};
    return r;
  endfunction

  function automatic req_t rand_any();
    req_t r;
    r = rand_std();
    r.c  = ($urandom_range(0, 3) == 0) ? 4'(9 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
    r.sp = ($urandom_range(0, 3) == 0);
    return r;
  endfunction

  task automatic test_reset();
    req_t z;
    z = '{1'b0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0};
    drive(z, 1'b0);
    hold = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({inp_valid, mode, cmd, opa, opb, cin, ce, issue_cnt, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got v=%b ce=%b cnt=%0d rdy=%b, required all zero", inp_valid, ce, issue_cnt, req_ready);
    end
    repeat (2) @(posedge clk);
    #3;
    n_checks++;
    if ({inp_valid, mode, cmd, opa, opb, cin, ce, issue_cnt, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: got v=%b ce=%b cnt=%0d rdy=%b, required all zero", inp_valid, ce, issue_cnt, req_ready);
    end
    rst_n = 1'b1;
    n_checks++;
    if (req_ready !== 1'b0 || ce !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_pre_edge: rdy=%b ce=%b, required 0 0", req_ready, ce);
    end
    tick();
    n_checks++;
    if (req_ready !== 1'b1 || ce !== 1'b1 || inp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_first_edge: rdy=%b ce=%b v=%b, required 1 1 00", req_ready, ce, inp_valid);
    end
    exp_cnt = '0;
  endtask

  task automatic test_single_add();
    req_t r;
    r = '{1'b1, 4'd0, 8'h12, 8'h34, 1'b0, 1'b0};
    drive(r, 1'b1);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %b required 1", req_ready); end
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (inp_valid !== 2'b00) begin n_fail++; $display("FAIL add_latency_%0d: v=%b required 00", i, inp_valid); end
      tick();
    end
    exp_cnt++;
    n_checks++;
    if ({inp_valid, mode, cmd, opa, opb, cin, issue_cnt} !== {2'b11, 1'b1, 4'd0, 8'h12, 8'h34, 1'b0, exp_cnt}) begin
      n_fail++;
      $display("FAIL add_issue: v=%b m=%b c=%h a=%h b=%h cnt=%0d, required 11 1 0 12 34 cnt=%0d",
               inp_valid, mode, cmd, opa, opb, issue_cnt, exp_cnt);
    end
    tick();
    n_checks++;
    if (inp_valid !== 2'b00 || issue_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL add_gap: v=%b cnt=%0d, required 00 cnt=%0d", inp_valid, issue_cnt, exp_cnt);
    end
    repeat (3) tick();
  endtask

  task automatic test_hold_fill();
    req_t e[5];
    obs_t s[$];
    logic [1:0] ev[12];
    int who[12];
    int pos;
    for (int k = 0; k < 5; k++) e[k] = rand_std();
    for (int i = 0; i < 12; i++) begin ev[i] = 2'b00; who[i] = -1; end
    pos = 1;
    for (int k = 0; k < 5; k++) begin ev[pos] = 2'b11; who[pos] = k; pos += 1 + gap_of(e[k]); end
    hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(e[k], 1'b1);
      n_checks++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d: got %b required 1", k, req_ready); end
      tick();
    end
    drive(e[4], 1'b1);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (req_ready !== 1'b0 || ce !== 1'b0 || inp_valid !== 2'b00) begin
        n_fail++;
        $display("FAIL fill_full_hold: rdy=%b ce=%b v=%b, required 0 0 00", req_ready, ce, inp_valid);
      end
      tick();
    end
    hold = 1'b0;
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL fill_no_bypass: rdy=%b required 0", req_ready); end
    tick();
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL fill_room_after_pop: rdy=%b required 1", req_ready); end
    s.push_back(sample());
    tick();
    req_valid = 1'b0;
    s.push_back(sample());
    repeat (10) begin tick(); s.push_back(sample()); end
    for (int i = 0; i < 12; i++) begin
      if (ev[i] == 2'b11) exp_cnt++;
      n_checks++;
      if (s[i].v !== ev[i] || s[i].n !== exp_cnt) begin
        n_fail++;
        $display("FAIL fill_pattern_%0d: v=%b cnt=%0d, required v=%b cnt=%0d", i, s[i].v, s[i].n, ev[i], exp_cnt);
      end else if (who[i] >= 0) begin
        n_checks++;
        if ({s[i].m, s[i].c, s[i].a, s[i].b, s[i].ci} !==
            {e[who[i]].m, e[who[i]].c, e[who[i]].a, e[who[i]].b, e[who[i]].ci}) begin
          n_fail++;
          $display("FAIL fill_order_%0d: got c=%h a=%h b=%h, required c=%h a=%h b=%h", who[i],
                   s[i].c, s[i].a, s[i].b, e[who[i]].c, e[who[i]].a, e[who[i]].b);
        end
      end
    end
  endtask

  task automatic test_mul_gap();
    req_t e[4];
    obs_t s[$];
    logic [1:0] ev[14];
    int who[14];
    int pos;
    e[0] = rand_std(); e[0].m = 1'b1; e[0].c = 4'd9;
    e[1] = rand_std(); e[1].m = 1'b0; e[1].c = 4'd0;
    e[2] = rand_std(); e[2].m = 1'b1; e[2].c = 4'd10;
    e[3] = rand_std(); e[3].m = 1'b0; e[3].c = 4'd9;
    for (int i = 0; i < 14; i++) begin ev[i] = 2'b00; who[i] = -1; end
    pos = 1;
    for (int k = 0; k < 4; k++) begin ev[pos] = 2'b11; who[pos] = k; pos += 1 + gap_of(e[k]); end
    hold = 1'b1;
    for (int k = 0; k < 4; k++) begin drive(e[k], 1'b1); tick(); end
    req_valid = 1'b0;
    hold = 1'b0;
    repeat (14) begin tick(); s.push_back(sample()); end
    for (int i = 0; i < 14; i++) begin
      if (ev[i] == 2'b11) exp_cnt++;
      n_checks++;
      if (s[i].v !== ev[i] || s[i].n !== exp_cnt ||
          (who[i] >= 0 && (s[i].c !== e[who[i]].c || s[i].m !== e[who[i]].m || s[i].a !== e[who[i]].a))) begin
        n_fail++;
        $display("FAIL mul_gap_%0d: v=%b m=%b c=%h cnt=%0d, required v=%b cnt=%0d", i, s[i].v, s[i].m, s[i].c,
                 s[i].n, ev[i], exp_cnt);
      end
    end
  endtask

`ifdef ALU_ISSUE_SPLIT_EN
  task automatic test_split();
    req_t r;
    r = '{1'b1, 4'd3, 8'hA5, 8'h5A, 1'b1, 1'b1};
    drive(r, 1'b1);
    tick();
    req_valid = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({inp_valid, mode, cmd, opa, opb, cin, issue_cnt} !== {2'b01, 1'b1, 4'd3, 8'hA5, 8'h00, 1'b1, exp_cnt}) begin
      n_fail++;
      $display("FAIL split_a: v=%b c=%h a=%h b=%h cnt=%0d, required 01 3 A5 00 cnt=%0d", inp_valid, cmd, opa, opb,
               issue_cnt, exp_cnt);
    end
    tick();
    exp_cnt++;
    n_checks++;
    if ({inp_valid, mode, cmd, opa, opb, cin, issue_cnt} !== {2'b10, 1'b1, 4'd3, 8'hA5, 8'h5A, 1'b1, exp_cnt}) begin
      n_fail++;
      $display("FAIL split_b: v=%b c=%h a=%h b=%h cnt=%0d, required 10 3 A5 5A cnt=%0d", inp_valid, cmd, opa, opb,
               issue_cnt, exp_cnt);
    end
    tick();
    n_checks++;
    if (inp_valid !== 2'b00 || issue_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL split_after: v=%b cnt=%0d, required 00 cnt=%0d", inp_valid, issue_cnt, exp_cnt);
    end
    repeat (3) tick();
  endtask

  task automatic test_hold_split();
    req_t r;
    r = rand_std();
    r.sp = 1'b1;
    drive(r, 1'b1);
    tick();
    req_valid = 1'b0;
    repeat (2) tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({ce, inp_valid, cmd, opa, opb, issue_cnt} !== {1'b0, 2'b01, r.c, r.a, 8'h00, exp_cnt}) begin
        n_fail++;
        $display("FAIL hold_split_frozen_%0d: ce=%b v=%b a=%h b=%h cnt=%0d, required 0 01 a=%h b=00 cnt=%0d", i,
                 ce, inp_valid, opa, opb, issue_cnt, r.a, exp_cnt);
      end
    end
    hold = 1'b0;
    tick();
    exp_cnt++;
    n_checks++;
    if ({ce, inp_valid, cmd, opa, opb, issue_cnt} !== {1'b1, 2'b10, r.c, r.a, r.b, exp_cnt}) begin
      n_fail++;
      $display("FAIL hold_split_resume: ce=%b v=%b a=%h b=%h cnt=%0d, required 1 10 a=%h b=%h cnt=%0d",
               ce, inp_valid, opa, opb, issue_cnt, r.a, r.b, exp_cnt);
    end
    repeat (4) tick();
  endtask
`endif

  task automatic test_random();
    req_t q[$];
    req_t r, cur;
    logic hold_prev, mid, seen_any, drain;
    logic [1:0] kind;
    logic [7:0] exp_b;
    int idle, need;
    mid = 1'b0; seen_any = 1'b0; idle = 0; need = 0;
    cur = rand_std();
    for (int cyc = 0; cyc < 800; cyc++) begin
      drain = (cyc >= 600);
      r = rand_any();
      drive(r, !drain && ($urandom_range(0, 99) < 55));
      hold = !drain && ($urandom_range(0, 99) < 20);
      if (req_valid && req_ready) q.push_back(r);
      hold_prev = hold;
      tick();
      n_checks++;
      if (ce !== !hold_prev) begin n_fail++; $display("FAIL rand_ce cyc %0d: ce=%b required %b", cyc, ce, !hold_prev); end
      if (ce === 1'b1) begin
        if (inp_valid == 2'b00) begin
          idle++;
          if (mid) begin
            n_checks++; n_fail++;
            $display("FAIL rand_split_gap cyc %0d: v=00 between A and B halves", cyc);
            mid = 1'b0;
          end
        end else if (inp_valid == 2'b10) begin
          exp_cnt++;
          n_checks++;
          if (!mid || {mode, cmd, opa, opb, cin, issue_cnt} !== {cur.m, cur.c, cur.a, cur.b, cur.ci, exp_cnt}) begin
            n_fail++;
            $display("FAIL rand_b cyc %0d: mid=%b a=%h b=%h cnt=%0d, required a=%h b=%h cnt=%0d", cyc, mid, opa, opb,
                     issue_cnt, cur.a, cur.b, exp_cnt);
          end
          mid = 1'b0; idle = 0; need = gap_of(cur);
        end else begin
          n_checks++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL rand_unexpected cyc %0d: v=%b with empty scoreboard", cyc, inp_valid);
          end else begin
            cur = q.pop_front();
            kind = first_kind(cur);
            exp_b = (kind == 2'b01) ? 8'h00 : cur.b;
            if (kind == 2'b11) exp_cnt++;
            if ({inp_valid, mode, cmd, opa, opb, cin, issue_cnt} !== {kind, cur.m, cur.c, cur.a, exp_b, cur.ci, exp_cnt}) begin
              n_fail++;
              $display("FAIL rand_issue cyc %0d: v=%b m=%b c=%h a=%h b=%h cnt=%0d, required v=%b m=%b c=%h a=%h b=%h cnt=%0d",
                       cyc, inp_valid, mode, cmd, opa, opb, issue_cnt, kind, cur.m, cur.c, cur.a, exp_b, exp_cnt);
            end
            if (seen_any) begin
              n_checks++;
              if (idle < need) begin
                n_fail++;
                $display("FAIL rand_gap cyc %0d: %0d idle cycles, required at least %0d", cyc, idle, need);
              end
            end
            if (kind == 2'b11) begin idle = 0; need = gap_of(cur); end else mid = 1'b1;
          end
          seen_any = 1'b1;
        end
      end
    end
    n_checks++;
    if (q.size() != 0 || mid || issue_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL rand_drain: %0d left, mid=%b cnt=%0d, required 0 0 cnt=%0d", q.size(), mid, issue_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_gap();
    req_t e;
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin e = rand_std(); drive(e, 1'b1); tick(); end
    req_valid = 1'b0;
    hold = 1'b0;
    repeat (2) tick();
    exp_cnt++;
    n_checks++;
    if (inp_valid !== 2'b11 || issue_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL rst_pre: v=%b cnt=%0d, required 11 cnt=%0d", inp_valid, issue_cnt, exp_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({inp_valid, mode, cmd, opa, opb, cin, ce, issue_cnt, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_async: v=%b a=%h ce=%b cnt=%0d rdy=%b, required all zero", inp_valid, opa, ce,
               issue_cnt, req_ready);
    end
    repeat (2) tick();
    #2 rst_n = 1'b1;
    exp_cnt = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (inp_valid !== 2'b00 || issue_cnt !== exp_cnt || req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_no_issue_%0d: v=%b cnt=%0d rdy=%b, required 00 0 1", i, inp_valid, issue_cnt, req_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_hold_fill();
    test_mul_gap();
`ifdef ALU_ISSUE_SPLIT_EN
    test_split();
    test_hold_split();
`endif
    test_random();
    test_reset_mid_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
